// File: rtl/tt_um_jimktrains_vslc_instr_fetch.sv
// ---------------------------------------------------------------------------
// tt_um_jimktrains_vslc_instr_fetch
//
// Instruction fetch stage that sits behind the VSLC EEPROM byte reader.
// Each serial-read byte is captured on the rising edge of the reader's
// ready level. Bytes are packed big-endian into INSTR_BYTES-wide words, and
// each word is tagged with the address of its first byte. Finished words are
// queued in a small FIFO for the execute stage.
//
// When the FIFO fills, the reader is frozen through hold_n. On a
// control-flow jump the reader is restarted at a new address by holding
// goto_address high for two cycles.
//
// Ports
//   clk, rst_n     clock (posedge) and synchronous active-low reset
//   byte_in        byte from the reader
//   byte_valid     reader ready level; a capture happens on its rising edge
//   byte_addr      EEPROM address of byte_in
//   hold_n         0 freezes the reader
//   goto_address   high for two cycles to restart the reader
//   jump_address   restart address handed to the reader
//   jump_req       one-cycle request to refetch from jump_target
//   jump_target    jump destination byte address
//   instr          FIFO head word, first byte in the MSBs
//   instr_pc       address of the first byte of instr
//   instr_valid    head word available (FIFO non-empty and not jumping)
//   instr_ready    consumer accepts the head word when instr_valid is high
//   fifo_count     number of words currently queued
// ---------------------------------------------------------------------------
module tt_um_jimktrains_vslc_instr_fetch #(
    parameter int INSTR_BYTES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        byte_in,
    input  logic                              byte_valid,
    input  logic [ADDR_W-1:0]                 byte_addr,
    output logic                              hold_n,
    output logic                              goto_address,
    output logic [ADDR_W-1:0]                 jump_address,
    input  logic                              jump_req,
    input  logic [ADDR_W-1:0]                 jump_target,
    output logic [8*INSTR_BYTES-1:0]          instr,
    output logic [ADDR_W-1:0]                 instr_pc,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int WORD_W = 8 * INSTR_BYTES;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BIDX_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_JUMP0,
        ST_JUMP1
    } state_t;

    state_t              state_q,     state_d;
    logic                bv_prev_q,   bv_prev_d;
    logic [WORD_W-1:0]   asm_word_q,  asm_word_d;
    logic [BIDX_W-1:0]   asm_idx_q,   asm_idx_d;
    logic [ADDR_W-1:0]   asm_pc_q,    asm_pc_d;
    logic                cw_valid_q,  cw_valid_d;
    logic [WORD_W-1:0]   cw_word_q,   cw_word_d;
    logic [ADDR_W-1:0]   cw_pc_q,     cw_pc_d;
    logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [CNT_W-1:0]    count_q,     count_d;
    logic                hold_n_q,    hold_n_d;
    logic                goto_q,      goto_d;
    logic [ADDR_W-1:0]   jump_addr_q, jump_addr_d;

    logic [WORD_W-1:0]   mem_word_q [FIFO_DEPTH];
    logic [WORD_W-1:0]   mem_word_d [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_pc_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_pc_d   [FIFO_DEPTH];

    logic                capture;
    logic                pop;
    logic                push;
    logic                pending_d;
    logic [WORD_W-1:0]   next_word;

    assign instr_valid  = (state_q == ST_RUN) && (count_q != '0);
    assign instr        = mem_word_q[rd_ptr_q];
    assign instr_pc     = mem_pc_q[rd_ptr_q];
    assign fifo_count   = count_q;
    assign hold_n       = hold_n_q;
    assign goto_address = goto_q;
    assign jump_address = jump_addr_q;

    // Next-state logic for the whole block.
    // The datapath is evaluated first: capture, assembly, and the FIFO
    // push/pop. The state machine is evaluated afterwards, so a jump
    // flush overrides whatever the datapath did in the same cycle. A
    // handshake in that cycle still counts as taken by the consumer.
    always_comb begin
        state_d     = state_q;
        bv_prev_d   = byte_valid;
        asm_word_d  = asm_word_q;
        asm_idx_d   = asm_idx_q;
        asm_pc_d    = asm_pc_q;
        cw_valid_d  = cw_valid_q;
        cw_word_d   = cw_word_q;
        cw_pc_d     = cw_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        jump_addr_d = jump_addr_q;
        mem_word_d  = mem_word_q;
        mem_pc_d    = mem_pc_q;

        // A frozen reader may keep byte_valid high, so only a rising edge
        // counts. The complete-word register is single entry, so nothing
        // new is taken while it is occupied.
        capture = (state_q == ST_RUN) && byte_valid && !bv_prev_q && !cw_valid_q;
        pop     = instr_valid && instr_ready;
        push    = cw_valid_q && ((count_q != FULL_COUNT) || pop);

        next_word = asm_word_q;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            if (asm_idx_q == BIDX_W'(k)) begin
                next_word[8*(INSTR_BYTES-k)-1 -: 8] = byte_in;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            mem_word_d[wr_ptr_q] = cw_word_q;
            mem_pc_d[wr_ptr_q]   = cw_pc_q;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            cw_valid_d           = 1'b0;
        end

        count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

        if (capture) begin
            asm_word_d = next_word;
            if (asm_idx_q == '0) begin
                asm_pc_d = byte_addr;
            end
            if (asm_idx_q == LAST_BYTE) begin
                asm_idx_d  = '0;
                cw_valid_d = 1'b1;
                cw_word_d  = next_word;
                cw_pc_d    = (asm_idx_q == '0) ? byte_addr : asm_pc_q;
            end else begin
                asm_idx_d = asm_idx_q + BIDX_W'(1);
            end
        end

        // A new jump request re-enters JUMP0 from any state. Re-entering
        // JUMP0 retargets the reader and restarts the two-cycle goto pulse.
        case (state_q)
            ST_RUN: begin
                if (jump_req) begin
                    state_d = ST_JUMP0;
                end
            end
            ST_JUMP0: begin
                state_d = jump_req ? ST_JUMP0 : ST_JUMP1;
            end
            ST_JUMP1: begin
                state_d = jump_req ? ST_JUMP0 : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (jump_req) begin
            jump_addr_d = jump_target;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            cw_valid_d  = 1'b0;
            asm_idx_d   = '0;
        end

        // The reader is held only when a word has nowhere to go. During a
        // jump, hold stays released so the reader can see the goto edge.
        goto_d    = (state_d != ST_RUN);
        pending_d = cw_valid_d && (count_d == FULL_COUNT);
        hold_n_d  = goto_d || !((count_d == FULL_COUNT) || pending_d);
    end

    // Control and datapath registers, with synchronous active-low reset.
    // A partially assembled word is dropped by clearing the byte index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            bv_prev_q   <= 1'b0;
            asm_word_q  <= '0;
            asm_idx_q   <= '0;
            asm_pc_q    <= '0;
            cw_valid_q  <= 1'b0;
            cw_word_q   <= '0;
            cw_pc_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            hold_n_q    <= 1'b1;
            goto_q      <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            bv_prev_q   <= bv_prev_d;
            asm_word_q  <= asm_word_d;
            asm_idx_q   <= asm_idx_d;
            asm_pc_q    <= asm_pc_d;
            cw_valid_q  <= cw_valid_d;
            cw_word_q   <= cw_word_d;
            cw_pc_q     <= cw_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            hold_n_q    <= hold_n_d;
            goto_q      <= goto_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    // FIFO storage needs no reset. Entries are only visible through
    // instr_valid, which depends on the count, and the count is reset.
    always_ff @(posedge clk) begin
        mem_word_q <= mem_word_d;
        mem_pc_q   <= mem_pc_d;
    end

endmodule
